// File: rtl/uart_block_tx.sv
// Framed block transmitter: buffers up to BLOCK_SIZE bytes from a valid/ready stream and
// sends them as SOF, LEN, payload, CHK over an integrated 8N1 serializer.
module uart_block_tx #(
    parameter int          BLOCK_SIZE   = 8,
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       flush,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                ADDR_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        BLOCK_LEN = 8'(BLOCK_SIZE);

    typedef enum logic [2:0] {
        S_FILL,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_reg;
    logic [7:0]        count_reg;
    logic [7:0]        len_reg;
    logic [7:0]        chk_reg;
    logic [7:0]        shift_reg;
    logic [8:0]        idx_reg;
    logic [2:0]        bit_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic              tx_reg;
    logic              done_reg;
    logic              run_reg;

    logic [7:0]        buf_mem [0:(1 << ADDR_W) - 1];
    logic [7:0]        rd_data_reg;

    logic              accept;
    logic [7:0]        count_next;
    logic [8:0]        idx_next;
    logic [8:0]        chk_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              baud_wrap;
    logic [7:0]        next_byte;

    assign accept     = s_valid && s_ready;
    assign count_next = count_reg + {7'd0, accept};
    assign idx_next   = idx_reg + 9'd1;
    assign chk_idx    = {1'b0, len_reg} + 9'd2;
    assign baud_wrap  = (baud_reg == BAUD_LAST);
    // Prefetch the payload byte for idx+1 while the current byte's stop bit is on the line.
    assign rd_addr    = ADDR_W'(idx_reg - 9'd1);

    always_comb begin
        next_byte = rd_data_reg;
        if (idx_next == 9'd1) begin
            next_byte = len_reg;
        end else if (idx_next == chk_idx) begin
            next_byte = len_reg ^ chk_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[count_reg[ADDR_W-1:0]] <= s_data;
        end
        rd_data_reg <= buf_mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FILL;
            count_reg <= 8'd0;
            len_reg   <= 8'd0;
            chk_reg   <= 8'd0;
            shift_reg <= 8'd0;
            idx_reg   <= 9'd0;
            bit_reg   <= 3'd0;
            baud_reg  <= '0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
            run_reg   <= 1'b0;
        end else begin
            run_reg  <= 1'b1;
            done_reg <= 1'b0;
            case (state_reg)
                S_FILL: begin
                    if (accept) begin
                        chk_reg <= chk_reg ^ s_data;
                    end
                    count_reg <= count_next;
                    if (count_next == BLOCK_LEN || (flush && count_next != 8'd0)) begin
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    len_reg   <= count_reg;
                    idx_reg   <= 9'd0;
                    shift_reg <= SOF_BYTE;
                    baud_reg  <= '0;
                    tx_reg    <= 1'b0;
                    state_reg <= S_START;
                end
                S_START: begin
                    if (baud_wrap) begin
                        baud_reg  <= '0;
                        bit_reg   <= 3'd0;
                        tx_reg    <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state_reg <= S_DATA;
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_wrap) begin
                        baud_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= S_STOP;
                        end else begin
                            bit_reg   <= bit_reg + 3'd1;
                            tx_reg    <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_wrap) begin
                        baud_reg <= '0;
                        if (idx_reg == chk_idx) begin
                            count_reg <= 8'd0;
                            chk_reg   <= 8'd0;
                            done_reg  <= 1'b1;
                            state_reg <= S_FILL;
                        end else begin
                            idx_reg   <= idx_next;
                            shift_reg <= next_byte;
                            tx_reg    <= 1'b0;
                            state_reg <= S_START;
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                default: state_reg <= S_FILL;
            endcase
        end
    end

    assign tx         = tx_reg;
    assign busy       = (state_reg != S_FILL);
    assign frame_done = done_reg;
    assign s_ready    = run_reg && (state_reg == S_FILL) && (count_reg < BLOCK_LEN);

endmodule

// File: tb/tb_uart_block_tx.sv
// Bench for uart_block_tx: a frame-level reference model predicts the tx waveform and
// handshake outputs every cycle, and a UART decoder recovers bytes from tx for frame checks.
module tb_uart_block_tx;

    localparam int         CPB = 4;
    localparam int         BS  = 8;
    localparam logic [7:0] SOF = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       flush = 1'b0;
    logic       s_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    uart_block_tx #(
        .BLOCK_SIZE  (BS),
        .CLKS_PER_BIT(CPB),
        .SOF_BYTE    (SOF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .flush     (flush),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned src[$];
    byte unsigned pay[$];
    byte unsigned exp_rx[$];
    byte unsigned rxq[$];
    bit           wave[$];
    bit           m_busy = 1'b0;
    bit           m_run  = 1'b0;
    bit           m_fd   = 1'b0;
    bit           m_acc  = 1'b0;
    int           m_frames = 0;
    int           fd_count = 0;
    int           busy_cnt = 0;
    bit           dec_on = 1'b0;
    int           dec_t = 0;
    logic [7:0]   dec_b = 8'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line: one idle cycle for LOAD, then 10 bits per frame byte, CPB cycles each.
    task automatic build_frame();
        byte unsigned fr[$];
        byte unsigned c;
        c = 8'(pay.size());
        fr.push_back(SOF);
        fr.push_back(8'(pay.size()));
        foreach (pay[i]) begin
            c ^= pay[i];
            fr.push_back(pay[i]);
        end
        fr.push_back(c);
        wave.delete();
        wave.push_back(1'b1);
        foreach (fr[i]) begin
            exp_rx.push_back(fr[i]);
            repeat (CPB) wave.push_back(1'b0);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) wave.push_back(fr[i][b]);
            end
            repeat (CPB) wave.push_back(1'b1);
        end
        pay.delete();
        m_frames++;
    endtask

    task automatic model_edge();
        m_acc = 1'b0;
        m_fd  = 1'b0;
        if (rst) begin
            pay.delete();
            wave.delete();
            m_busy = 1'b0;
            m_run  = 1'b0;
        end else begin
            if (m_busy) begin
                void'(wave.pop_front());
                if (wave.size() == 0) begin
                    m_busy = 1'b0;
                    m_fd   = 1'b1;
                end
            end else begin
                if (s_valid && m_run && pay.size() < BS) begin
                    pay.push_back(s_data);
                    m_acc = 1'b1;
                end
                if (pay.size() == BS || (flush && pay.size() > 0)) begin
                    build_frame();
                    m_busy = 1'b1;
                end
            end
            m_run = 1'b1;
        end
        if (m_acc) void'(src.pop_front());
    endtask

    task automatic compare_outputs();
        check_eq("tx", tx, m_busy ? wave[0] : 1'b1);
        check_eq("busy", busy, m_busy);
        check_eq("frame_done", frame_done, m_fd);
        check_eq("s_ready", s_ready, m_run && !m_busy && pay.size() < BS);
        busy_cnt += busy;
        fd_count += frame_done;
        if (!dec_on) begin
            if (tx == 1'b0) begin
                dec_on = 1'b1;
                dec_t  = 0;
            end
        end else begin
            dec_t++;
            if (dec_t >= 6 && dec_t <= 34 && (dec_t - 6) % 4 == 0) dec_b[(dec_t - 6) / 4] = tx;
            if (dec_t == 38) check_eq("stop_bit", tx, 1'b1);
            if (dec_t == 39) begin
                rxq.push_back(dec_b);
                dec_on = 1'b0;
            end
        end
    endtask

    task automatic step(input bit fl, input bit gap);
        flush   = fl;
        s_valid = (src.size() > 0) && !gap;
        s_data  = (src.size() > 0) ? src[0] : 8'($urandom);
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic run_idle(input int maxc);
        int k;
        k = 0;
        while ((m_busy || src.size() > 0) && k < maxc) begin
            step(1'b0, 1'b0);
            k++;
        end
        check_eq("idle_reached", k < maxc, 1'b1);
    endtask

    task automatic check_rx(input string tag, input byte unsigned e[$]);
        check_eq({tag, "_len"}, rxq.size(), e.size());
        foreach (e[i]) begin
            if (i < rxq.size()) check_eq({tag, "_byte"}, rxq[i], e[i]);
        end
        rxq.delete();
        exp_rx.delete();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_s_ready", s_ready, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        src.delete();
        rxq.delete();
        exp_rx.delete();
        dec_on = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned e[$];
        int           k;
        int           n;

        #1 rst = 1'b1;
        #2;
        check_eq("init_tx", tx, 1'b1);
        check_eq("init_busy", busy, 1'b0);
        check_eq("init_s_ready", s_ready, 1'b0);
        check_eq("init_frame_done", frame_done, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);

        // Full block 01..08
        busy_cnt = 0;
        fd_count = 0;
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        run_idle(600);
        check_eq("full_busy_cycles", busy_cnt, 441);
        check_eq("full_done_pulses", fd_count, 1);
        e = '{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
        check_rx("full", e);

        // Partial block then flush; flush on an empty buffer does nothing
        src = '{8'h3C, 8'h5A};
        run_idle(20);
        step(1'b1, 1'b0);
        run_idle(400);
        e = '{8'hA5, 8'h02, 8'h3C, 8'h5A, 8'h64};
        check_rx("partial", e);
        fd_count = 0;
        repeat (6) step(1'b1, 1'b0);
        check_eq("empty_flush_rx", rxq.size(), 0);
        check_eq("empty_flush_done", fd_count, 0);

        // Flush on the same edge as the only accept
        src = '{8'h7E};
        step(1'b1, 1'b0);
        run_idle(300);
        e = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        check_rx("coincident", e);

        // Backpressure: 99 waits through a whole frame, then leads the next one
        fd_count = 0;
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h10 + i));
        src.push_back(8'h99);
        run_idle(1000);
        step(1'b1, 1'b0);
        run_idle(400);
        check_eq("backpressure_done_pulses", fd_count, 2);
        e = '{8'hA5, 8'h08, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h08,
              8'hA5, 8'h01, 8'h99, 8'h98};
        check_rx("backpressure", e);

        // Randomized traffic with gaps and sporadic flushes
        rxq.delete();
        exp_rx.delete();
        fd_count = 0;
        m_frames = 0;
        repeat (12) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) src.push_back(8'($urandom));
            k = 0;
            while ((src.size() > 0 || m_busy) && k < 3000) begin
                step($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
                k++;
            end
            check_eq("rand_progress", k < 3000, 1'b1);
            step(1'b1, 1'b0);
            run_idle(1000);
        end
        check_eq("rand_done_pulses", fd_count, m_frames);
        e = exp_rx;
        check_rx("random", e);

        // Reset during DATA of payload[2], then a fresh 1-byte frame
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h20 + i));
        k = 0;
        while (!m_busy && k < 20) begin
            step(1'b0, 1'b0);
            k++;
        end
        check_eq("midreset_started", m_busy, 1'b1);
        repeat (170) step(1'b0, 1'b0);
        async_reset();
        check_eq("post_reset_ready", s_ready, 1'b1);
        src = '{8'hC3};
        step(1'b1, 1'b0);
        run_idle(300);
        e = '{8'hA5, 8'h01, 8'hC3, 8'hC2};
        check_rx("after_reset", e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
